// File: rtl/deltaw2_gen.sv
// -----------------------------------------------------------------------------
// deltaw2_gen
//   Writer side of the layer-2 weight store. On an accepted start it latches the
//   five output-layer error terms, then walks the nine hidden rows (one per
//   cycle), computing deltaw2_ij = (err_j * h_i) >>> (8 + LR_SHIFT) for all five
//   columns of each row. After the last row it raises a one-cycle commit code
//   (upd_sel = upd_ctrl = 4'hF) so the weight store adds all 45 deltas, and
//   pulses done on the following cycle.
//
// Parameters
//   LR_SHIFT          learning rate as a right shift (lr = 2^-LR_SHIFT), 0..7
//
// Configuration macro
//   DELTAW2_SAT_EN    defined: shifted product saturates to [-32768, 32767]
//                     undefined: shifted product wraps to its low 16 bits
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   start             request one delta computation (sampled only in IDLE)
//   err_1..err_5      signed Q8.8 error terms, latched on accepted start
//   h_idx             hidden-row index 0..8 to the activation source
//   h_in              signed Q8.8 activation for h_idx, same-cycle valid
//   deltaw2_11..95    signed Q8.8 registered deltas, row 1..9 x column 1..5
//   upd_sel/upd_ctrl  commit code to the weight store, 4'hF only in COMMIT
//   busy              high in CALC and COMMIT
//   done              one-cycle pulse after COMMIT
// -----------------------------------------------------------------------------
module deltaw2_gen #(
  parameter int LR_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] err_1, err_2, err_3, err_4, err_5,
  output logic [3:0]  h_idx,
  input  logic [15:0] h_in,
  output logic [15:0] deltaw2_11, deltaw2_12, deltaw2_13, deltaw2_14, deltaw2_15,
  output logic [15:0] deltaw2_21, deltaw2_22, deltaw2_23, deltaw2_24, deltaw2_25,
  output logic [15:0] deltaw2_31, deltaw2_32, deltaw2_33, deltaw2_34, deltaw2_35,
  output logic [15:0] deltaw2_41, deltaw2_42, deltaw2_43, deltaw2_44, deltaw2_45,
  output logic [15:0] deltaw2_51, deltaw2_52, deltaw2_53, deltaw2_54, deltaw2_55,
  output logic [15:0] deltaw2_61, deltaw2_62, deltaw2_63, deltaw2_64, deltaw2_65,
  output logic [15:0] deltaw2_71, deltaw2_72, deltaw2_73, deltaw2_74, deltaw2_75,
  output logic [15:0] deltaw2_81, deltaw2_82, deltaw2_83, deltaw2_84, deltaw2_85,
  output logic [15:0] deltaw2_91, deltaw2_92, deltaw2_93, deltaw2_94, deltaw2_95,
  output logic [3:0]  upd_sel,
  output logic [3:0]  upd_ctrl,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [3:0]         row;
  logic signed [15:0] err_q  [5];
  logic [15:0]        dw     [9][5];

  logic signed [31:0] prod   [5];
  logic signed [31:0] quot   [5];
  logic [15:0]        row_dw [5];

  // Deltas for the row currently addressed by h_idx; loaded at the next edge.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      // Full-precision signed product, then floor shift (no rounding).
      prod[j] = 32'(err_q[j]) * 32'($signed(h_in));
      quot[j] = prod[j] >>> (8 + LR_SHIFT);
`ifdef DELTAW2_SAT_EN
      if (quot[j] > 32'sd32767)
        row_dw[j] = 16'h7FFF;
      else if (quot[j] < -32'sd32768)
        row_dw[j] = 16'h8000;
      else
        row_dw[j] = quot[j][15:0];
`else
      row_dw[j] = quot[j][15:0];
`endif
    end
  end

  // NOTE: every always_comb signal gets a default before the case so no path
  // leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (row == 4'd8) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Commit code and row index decode straight from state so they can never
  // linger into IDLE.
  assign busy     = (state != IDLE);
  assign upd_sel  = (state == COMMIT) ? 4'hF : 4'h0;
  assign upd_ctrl = (state == COMMIT) ? 4'hF : 4'h0;
  assign h_idx    = (state == CALC) ? row : 4'd0;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= 4'd0;
      done  <= 1'b0;
      err_q <= '{default: '0};
      // NOTE: the delta array is a bank of flops, not a RAM, so clearing it in
      // reset is cheap and guarantees an aborted run leaves nothing to commit.
      dw    <= '{default: '{default: '0}};
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            err_q <= '{err_1, err_2, err_3, err_4, err_5};
            row   <= 4'd0;
          end
        end
        CALC: begin
          dw[row] <= row_dw;
          row     <= row + 4'd1;
        end
        COMMIT: begin
          done <= 1'b1;
          row  <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign deltaw2_11 = dw[0][0]; assign deltaw2_12 = dw[0][1]; assign deltaw2_13 = dw[0][2];
  assign deltaw2_14 = dw[0][3]; assign deltaw2_15 = dw[0][4];
  assign deltaw2_21 = dw[1][0]; assign deltaw2_22 = dw[1][1]; assign deltaw2_23 = dw[1][2];
  assign deltaw2_24 = dw[1][3]; assign deltaw2_25 = dw[1][4];
  assign deltaw2_31 = dw[2][0]; assign deltaw2_32 = dw[2][1]; assign deltaw2_33 = dw[2][2];
  assign deltaw2_34 = dw[2][3]; assign deltaw2_35 = dw[2][4];
  assign deltaw2_41 = dw[3][0]; assign deltaw2_42 = dw[3][1]; assign deltaw2_43 = dw[3][2];
  assign deltaw2_44 = dw[3][3]; assign deltaw2_45 = dw[3][4];
  assign deltaw2_51 = dw[4][0]; assign deltaw2_52 = dw[4][1]; assign deltaw2_53 = dw[4][2];
  assign deltaw2_54 = dw[4][3]; assign deltaw2_55 = dw[4][4];
  assign deltaw2_61 = dw[5][0]; assign deltaw2_62 = dw[5][1]; assign deltaw2_63 = dw[5][2];
  assign deltaw2_64 = dw[5][3]; assign deltaw2_65 = dw[5][4];
  assign deltaw2_71 = dw[6][0]; assign deltaw2_72 = dw[6][1]; assign deltaw2_73 = dw[6][2];
  assign deltaw2_74 = dw[6][3]; assign deltaw2_75 = dw[6][4];
  assign deltaw2_81 = dw[7][0]; assign deltaw2_82 = dw[7][1]; assign deltaw2_83 = dw[7][2];
  assign deltaw2_84 = dw[7][3]; assign deltaw2_85 = dw[7][4];
  assign deltaw2_91 = dw[8][0]; assign deltaw2_92 = dw[8][1]; assign deltaw2_93 = dw[8][2];
  assign deltaw2_94 = dw[8][3]; assign deltaw2_95 = dw[8][4];

endmodule

// File: tb/tb_deltaw2_gen.sv
// -----------------------------------------------------------------------------
// tb_deltaw2_gen
//   Two instances of deltaw2_gen (LR_SHIFT = 3 and LR_SHIFT = 0) share clock,
//   reset, start and error inputs. Each run pushes the expected 45 deltas for
//   both instances into a scoreboard; a monitor pops and compares whenever the
//   commit code appears, and also checks commit latency and the done pulse.
// -----------------------------------------------------------------------------
module tb_deltaw2_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] err_1 = '0, err_2 = '0, err_3 = '0, err_4 = '0, err_5 = '0;
  logic [15:0] h_tab [9];

  wire  [3:0]  h_idx3, h_idx0;
  logic [15:0] h_in3, h_in0;
  wire  [15:0] o3 [45];
  wire  [15:0] o0 [45];
  wire  [3:0]  sel3, ctrl3, sel0, ctrl0;
  wire         busy3, done3, busy0, done0;

  int          n_total = 0;
  int          n_pass  = 0;
  int unsigned cyc     = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] d3 [45];
    logic [15:0] d0 [45];
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  bit   after_commit = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Activation source: combinational lookup by row index.
  assign h_in3 = (h_idx3 < 4'd9) ? h_tab[h_idx3] : 16'hDEAD;
  assign h_in0 = (h_idx0 < 4'd9) ? h_tab[h_idx0] : 16'hDEAD;

  deltaw2_gen #(.LR_SHIFT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .err_1(err_1), .err_2(err_2), .err_3(err_3), .err_4(err_4), .err_5(err_5),
    .h_idx(h_idx3), .h_in(h_in3),
    .deltaw2_11(o3[0]),  .deltaw2_12(o3[1]),  .deltaw2_13(o3[2]),  .deltaw2_14(o3[3]),  .deltaw2_15(o3[4]),
    .deltaw2_21(o3[5]),  .deltaw2_22(o3[6]),  .deltaw2_23(o3[7]),  .deltaw2_24(o3[8]),  .deltaw2_25(o3[9]),
    .deltaw2_31(o3[10]), .deltaw2_32(o3[11]), .deltaw2_33(o3[12]), .deltaw2_34(o3[13]), .deltaw2_35(o3[14]),
    .deltaw2_41(o3[15]), .deltaw2_42(o3[16]), .deltaw2_43(o3[17]), .deltaw2_44(o3[18]), .deltaw2_45(o3[19]),
    .deltaw2_51(o3[20]), .deltaw2_52(o3[21]), .deltaw2_53(o3[22]), .deltaw2_54(o3[23]), .deltaw2_55(o3[24]),
    .deltaw2_61(o3[25]), .deltaw2_62(o3[26]), .deltaw2_63(o3[27]), .deltaw2_64(o3[28]), .deltaw2_65(o3[29]),
    .deltaw2_71(o3[30]), .deltaw2_72(o3[31]), .deltaw2_73(o3[32]), .deltaw2_74(o3[33]), .deltaw2_75(o3[34]),
    .deltaw2_81(o3[35]), .deltaw2_82(o3[36]), .deltaw2_83(o3[37]), .deltaw2_84(o3[38]), .deltaw2_85(o3[39]),
    .deltaw2_91(o3[40]), .deltaw2_92(o3[41]), .deltaw2_93(o3[42]), .deltaw2_94(o3[43]), .deltaw2_95(o3[44]),
    .upd_sel(sel3), .upd_ctrl(ctrl3), .busy(busy3), .done(done3)
  );

  deltaw2_gen #(.LR_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .err_1(err_1), .err_2(err_2), .err_3(err_3), .err_4(err_4), .err_5(err_5),
    .h_idx(h_idx0), .h_in(h_in0),
    .deltaw2_11(o0[0]),  .deltaw2_12(o0[1]),  .deltaw2_13(o0[2]),  .deltaw2_14(o0[3]),  .deltaw2_15(o0[4]),
    .deltaw2_21(o0[5]),  .deltaw2_22(o0[6]),  .deltaw2_23(o0[7]),  .deltaw2_24(o0[8]),  .deltaw2_25(o0[9]),
    .deltaw2_31(o0[10]), .deltaw2_32(o0[11]), .deltaw2_33(o0[12]), .deltaw2_34(o0[13]), .deltaw2_35(o0[14]),
    .deltaw2_41(o0[15]), .deltaw2_42(o0[16]), .deltaw2_43(o0[17]), .deltaw2_44(o0[18]), .deltaw2_45(o0[19]),
    .deltaw2_51(o0[20]), .deltaw2_52(o0[21]), .deltaw2_53(o0[22]), .deltaw2_54(o0[23]), .deltaw2_55(o0[24]),
    .deltaw2_61(o0[25]), .deltaw2_62(o0[26]), .deltaw2_63(o0[27]), .deltaw2_64(o0[28]), .deltaw2_65(o0[29]),
    .deltaw2_71(o0[30]), .deltaw2_72(o0[31]), .deltaw2_73(o0[32]), .deltaw2_74(o0[33]), .deltaw2_75(o0[34]),
    .deltaw2_81(o0[35]), .deltaw2_82(o0[36]), .deltaw2_83(o0[37]), .deltaw2_84(o0[38]), .deltaw2_85(o0[39]),
    .deltaw2_91(o0[40]), .deltaw2_92(o0[41]), .deltaw2_93(o0[42]), .deltaw2_94(o0[43]), .deltaw2_95(o0[44]),
    .upd_sel(sel0), .upd_ctrl(ctrl0), .busy(busy0), .done(done0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic: signed Q8.8 product, floor shift, then saturate/wrap.
  function automatic logic [15:0] model(input logic [15:0] e, input logic [15:0] h, input int sh);
    logic signed [31:0] p, q;
    p = 32'($signed(e)) * 32'($signed(h));
    q = p >>> (8 + sh);
`ifdef DELTAW2_SAT_EN
    if (q > 32'sd32767)  return 16'h7FFF;
    if (q < -32'sd32768) return 16'h8000;
`endif
    return q[15:0];
  endfunction

  // Monitor: compares against the scoreboard whenever the commit code shows.
  always @(negedge clk) begin
    if (!rst) begin
      if (sel3 == 4'hF || ctrl3 == 4'hF || sel0 == 4'hF || ctrl0 == 4'hF) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", {16'h0, sel3, ctrl3, sel0, ctrl0}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("commit_latency", cyc, mon_e.cyc);
          check("commit_code3", {sel3, ctrl3}, 8'hFF);
          check("commit_code0", {sel0, ctrl0}, 8'hFF);
          check("commit_busy", {busy3, busy0}, 2'b11);
          for (int k = 0; k < 45; k++) begin
            check($sformatf("dw3_%0d%0d", k / 5 + 1, k % 5 + 1), o3[k], mon_e.d3[k]);
            check($sformatf("dw0_%0d%0d", k / 5 + 1, k % 5 + 1), o0[k], mon_e.d0[k]);
          end
        end
        after_commit = 1'b1;
      end else begin
        check("done3", done3, after_commit);
        check("done0", done0, after_commit);
        if (after_commit) check("busy_in_done", {busy3, busy0}, 2'b00);
        after_commit = 1'b0;
      end
    end
  end

  // One complete run. Returns in the done cycle so the next call is back-to-back.
  task automatic run_iter(input logic [4:0][15:0] e, input logic [8:0][15:0] hv, input bit poke);
    exp_t x;
    err_1 = e[0]; err_2 = e[1]; err_3 = e[2]; err_4 = e[3]; err_5 = e[4];
    for (int k = 0; k < 9; k++) h_tab[k] = hv[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x.cyc = cyc + 9;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 5; j++) begin
        x.d3[i*5+j] = model(e[j], hv[i], 3);
        x.d0[i*5+j] = model(e[j], hv[i], 0);
      end
    sb.push_back(x);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("h_idx3", h_idx3, k);
      check("h_idx0", h_idx0, k);
      if (poke && k == 3) begin
        start = 1'b1;
        err_3 = 16'h7000;
      end
      if (poke && k == 4) start = 1'b0;
    end
    @(negedge clk);  // COMMIT
    @(negedge clk);  // done
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, {busy3, busy0}, 2'b00);
    check({tag, "_done"}, {done3, done0}, 2'b00);
    check({tag, "_h_idx"}, {h_idx3, h_idx0}, 8'h00);
    check({tag, "_upd"}, {sel3, ctrl3, sel0, ctrl0}, 16'h0000);
    for (int k = 0; k < 45; k++) begin
      check($sformatf("%s_dw3_%0d", tag, k), o3[k], 16'h0000);
      check($sformatf("%s_dw0_%0d", tag, k), o0[k], 16'h0000);
    end
  endtask

  logic [4:0][15:0] ev;
  logic [8:0][15:0] hv;

  initial begin
    for (int k = 0; k < 9; k++) h_tab[k] = 16'h0000;

    // Reset held two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // err_1 = 1.0, h = 2.0, LR_SHIFT 3 -> 2.0/8 = 0x0040.
    ev = '0; ev[0] = 16'h0100;
    for (int k = 0; k < 9; k++) hv[k] = 16'h0200;
    run_iter(ev, hv, 1'b0);
    for (int i = 0; i < 9; i++) check("t2_dw3_i1", o3[i*5], 16'h0040);

    // err_2 = -1.0, h = 0.5, LR_SHIFT 3 -> -0.0625 = 0xFFF0.
    ev = '0; ev[1] = 16'hFF00;
    for (int k = 0; k < 9; k++) hv[k] = 16'h0080;
    run_iter(ev, hv, 1'b0);
    for (int i = 0; i < 9; i++) check("t3_dw3_i2", o3[i*5+1], 16'hFFF0);

    // Max positive squared, LR_SHIFT 0: saturates or wraps to 0xFF00.
    ev = '0; ev[4] = 16'h7FFF;
    for (int k = 0; k < 9; k++) hv[k] = 16'h7FFF;
    run_iter(ev, hv, 1'b0);
`ifdef DELTAW2_SAT_EN
    for (int i = 0; i < 9; i++) check("t4_dw0_i5", o0[i*5+4], 16'h7FFF);
`else
    for (int i = 0; i < 9; i++) check("t4_dw0_i5", o0[i*5+4], 16'hFF00);
`endif

    // Ramp activations; start pulse and err_3 change mid-CALC must be ignored.
    ev = '0; ev[2] = 16'h0100;
    for (int k = 0; k < 9; k++) hv[k] = 16'(16'h0100 * (k + 1));
    run_iter(ev, hv, 1'b1);
    for (int i = 0; i < 9; i++) check("t5_dw0_i3", o0[i*5+2], 16'(16'h0100 * (i + 1)));

    // Mixed signs and extremes across all columns.
    ev = {16'h0040, 16'h8000, 16'h0100, 16'h0333, 16'hFF80};
    hv = {16'h0080, 16'hFFFF, 16'h1234, 16'h0000, 16'h0001,
          16'h8000, 16'h7FFF, 16'hFF00, 16'h0100};
    run_iter(ev, hv, 1'b0);

    // Reset on the 5th CALC cycle: abort, no commit, deltas cleared.
    ev = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    err_1 = ev[0]; err_2 = ev[1]; err_3 = ev[2]; err_4 = ev[3]; err_5 = ev[4];
    for (int k = 0; k < 9; k++) h_tab[k] = 16'h0400;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Normal run after the abort.
    ev = {16'hFE00, 16'h0010, 16'h0200, 16'h7FFF, 16'h0180};
    hv = {16'h0300, 16'hFD00, 16'h0101, 16'h7F00, 16'h8001,
          16'h0002, 16'hFFFE, 16'h0400, 16'hC000};
    run_iter(ev, hv, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
